wallace_seq_mult_ctrl: RTL and testbench



---
 rtl/wallace_seq_mult_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_wallace_seq_mult_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// wallace_seq_mult_ctrl
//
// Multi-cycle WIDTH x WIDTH unsigned multiplier that reuses a single 3x3
// Wallace-tree core. Both operands are cut into D = WIDTH/3 three-bit digits.
// One digit pair is multiplied per cycle, and each 6-bit partial product is
// shifted into place and accumulated. The 2*WIDTH-bit product is then offered
// on a valid/ready handshake.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands present on in1/in2
//   in_ready   out  1        controller can accept operands (IDLE)
//   in1        in   WIDTH    multiplicand, unsigned
//   in2        in   WIDTH    multiplier, unsigned
//   out_valid  out  1        product valid on out (DONE)
//   out_ready  in   1        consumer accepts product
//   out        out  2*WIDTH  product in1*in2
//   busy       out  1        high in MUL or DONE
//
// The file also holds the exact 3x3 core, wallace_three_bit_multiplier.
// An approximate core with the same ports can replace it.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// wallace_three_bit_multiplier
//
// Exact 3x3 unsigned multiplier. A single Wallace reduction layer is followed
// by a carry-propagate adder.
//
// Ports
//   a  in   3  multiplicand digit
//   b  in   3  multiplier digit
//   p  out  6  product a*b
// ---------------------------------------------------------------------------
module wallace_three_bit_multiplier (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);

  // Partial-product bit pp_ij is a[j] & b[i]. It has weight i+j.
  logic pp00_s, pp01_s, pp02_s;
  logic pp10_s, pp11_s, pp12_s;
  logic pp20_s, pp21_s, pp22_s;

  // Signals produced by the reduction layer.
  logic s1_s, c2_s;       // half adder at weight 1
  logic s2_s, c3_s;       // full adder at weight 2
  logic s3_s, c4_s;       // half adder at weight 3
  logic [5:0] row_sum_s;  // sum bits, aligned
  logic [5:0] row_car_s;  // carry bits, aligned

  // Form the AND-array of partial-product bits.
  always_comb begin
    pp00_s = a[0] & b[0];
    pp01_s = a[1] & b[0];
    pp02_s = a[2] & b[0];
    pp10_s = a[0] & b[1];
    pp11_s = a[1] & b[1];
    pp12_s = a[2] & b[1];
    pp20_s = a[0] & b[2];
    pp21_s = a[1] & b[2];
    pp22_s = a[2] & b[2];
  end

  // Reduce the three-high column and the two-high columns to two rows,
  // then add the two rows in a final carry-propagate adder.
  always_comb begin
    s1_s = pp01_s ^ pp10_s;
    c2_s = pp01_s & pp10_s;
    s2_s = pp02_s ^ pp11_s ^ pp20_s;
    c3_s = (pp02_s & pp11_s) | (pp02_s & pp20_s) | (pp11_s & pp20_s);
    s3_s = pp12_s ^ pp21_s;
    c4_s = pp12_s & pp21_s;
    row_sum_s = {1'b0, pp22_s, s3_s, s2_s, s1_s, pp00_s};
    row_car_s = {1'b0, c4_s, c3_s, c2_s, 1'b0, 1'b0};
    p = row_sum_s + row_car_s;
  end

endmodule

// ---------------------------------------------------------------------------
// wallace_seq_mult_ctrl: sequential controller around the shared core.
// ---------------------------------------------------------------------------
module wallace_seq_mult_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int D  = WIDTH / 3;                      // digit count
  localparam int PW = 2 * WIDTH;                      // product width
  localparam int CW = (D > 1) ? $clog2(D) : 1;        // digit counter width
  localparam int DP = 2 ** CW;                        // padded digit table size
  localparam int SW = $clog2(PW) + 1;                 // shift amount width
  localparam logic [CW-1:0] LAST_DIG = CW'(D - 1);

  // The digit slicing below assumes the operands split exactly into 3-bit
  // digits.
  if ((WIDTH % 3 != 0) || (WIDTH < 3)) begin : g_bad_width
    $error("wallace_seq_mult_ctrl: WIDTH must be a multiple of 3 and >= 3");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic [PW-1:0]    out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [2:0]       a_digs_s [DP];
  logic [2:0]       b_digs_s [DP];
  logic [2:0]       core_a_s;
  logic [2:0]       core_b_s;
  logic [5:0]       core_p_s;
  logic [SW-1:0]    shamt_s;
  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    acc_sum_s;
  logic             last_pair_s;

  // The digit tables are padded to a power of two. The counters therefore
  // index them directly, and any unused slot reads as zero.
  for (genvar k = 0; k < DP; k++) begin : g_dig
    if (k < D) begin : g_real
      assign a_digs_s[k] = a_q[3*k +: 3];
      assign b_digs_s[k] = b_q[3*k +: 3];
    end else begin : g_pad
      assign a_digs_s[k] = 3'b000;
      assign b_digs_s[k] = 3'b000;
    end
  end

  // Drive the core only while multiplying, and hold its inputs at zero
  // otherwise.
  always_comb begin
    if (state_q == ST_MUL) begin
      core_a_s = a_digs_s[i_q];
      core_b_s = b_digs_s[j_q];
    end else begin
      core_a_s = 3'b000;
      core_b_s = 3'b000;
    end
  end

  wallace_three_bit_multiplier u_core (
    .a (core_a_s),
    .b (core_b_s),
    .p (core_p_s)
  );

  // Weight the partial product by 8^(i+j) and add it to the running sum.
  // The accumulator is the full product width, so the sum cannot overflow.
  always_comb begin
    shamt_s     = SW'(3) * (SW'(i_q) + SW'(j_q));
    addend_s    = PW'(core_p_s) << shamt_s;
    acc_sum_s   = acc_q + addend_s;
    last_pair_s = (i_q == LAST_DIG) && (j_q == LAST_DIG);
  end

  // Next-state and next-output logic: everything holds unless a
  // transition changes it.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = in1;
          b_d        = in2;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          state_d    = ST_MUL;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = acc_sum_s;
        if (last_pair_s) begin
          // This edge completes the final digit pair, so the sum is the
          // product.
          out_d       = acc_sum_s;
          out_valid_d = 1'b1;
          i_d         = '0;
          j_d         = '0;
          state_d     = ST_DONE;
        end else if (j_q == LAST_DIG) begin
          j_d = '0;
          i_d = i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wallace_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wallace_seq_mult_ctrl
//
// Self-checking bench for wallace_seq_mult_ctrl, with a WIDTH=6 instance and
// a WIDTH=9 instance. The reference is plain integer multiplication with a
// cycle-level timing model of the handshake.
// ---------------------------------------------------------------------------
module tb_wallace_seq_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in1;
  logic [5:0]  in2;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dut_out;
  logic        busy;

  logic        in9_valid;
  logic        in9_ready;
  logic [8:0]  in9_a;
  logic [8:0]  in9_b;
  logic        out9_valid;
  logic        out9_ready;
  logic [17:0] out9;
  logic        busy9;

  int n_checks;
  int n_pass;

  wallace_seq_mult_ctrl #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out),
    .busy      (busy)
  );

  wallace_seq_mult_ctrl #(.WIDTH(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in9_valid),
    .in_ready  (in9_ready),
    .in1       (in9_a),
    .in2       (in9_b),
    .out_valid (out9_valid),
    .out_ready (out9_ready),
    .out       (out9),
    .busy      (busy9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product of two 6-bit operands.
  function automatic logic [11:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    return 12'(a) * 12'(b);
  endfunction

  // Run one complete operation on the WIDTH=6 instance with out_ready high
  // from the start.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_before"}, 64'(in_ready), 64'(1));
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    tick();                       // accept edge E0
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(4));
    check({tag, "_product"}, 64'(dut_out), 64'(ref_mul(a, b)));
    tick();                       // handshake edge
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin : main
    int n;
    int cyc;
    int sent;
    int recvd;
    int ph;
    int last_acc;
    logic will_acc;
    logic exp_rdy;
    logic [11:0] exp_q[$];

    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in1        = 6'd0;
    in2        = 6'd0;
    out_ready  = 1'b0;
    in9_valid  = 1'b0;
    in9_a      = 9'd0;
    in9_b      = 9'd0;
    out9_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out", 64'(dut_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed products, including the maximum and a zero operand
    run_op(6'd45, 6'd27, "p45x27");
    run_op(6'd63, 6'd63, "p63x63");
    run_op(6'd0, 6'd51, "p0x51");

    // Backpressure, with in_valid pulses ignored while the controller is busy
    out_ready = 1'b0;
    in1 = 6'd5;
    in2 = 6'd6;
    in_valid = 1'b1;
    tick();                       // accept 5*6
    in1 = 6'd7;
    in2 = 6'd7;
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = ~in_valid;
      tick();
      n++;
    end
    check("bp_latency", 64'(n), 64'(4));
    for (int k = 0; k < 6; k++) begin
      check("bp_out_hold", 64'(dut_out), 64'(30));
      check("bp_valid_hold", 64'(out_valid), 64'(1));
      check("bp_not_ready", 64'(in_ready), 64'(0));
      in_valid = k[0];
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'(0));
    check("bp_release_ready", 64'(in_ready), 64'(1));
    tick();
    check("bp_no_queue_ready", 64'(in_ready), 64'(1));
    check("bp_no_queue_busy", 64'(busy), 64'(0));
    run_op(6'd7, 6'd7, "p7x7");

    // Asynchronous reset during the second MUL cycle
    in1 = 6'd45;
    in2 = 6'd27;
    in_valid = 1'b1;
    tick();                       // E0 accept
    in_valid = 1'b0;
    tick();                       // E1, now in second MUL cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out", 64'(dut_out), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(6'd9, 6'd9, "p9x9");

    // Back-to-back random operations, in_valid held high, out_ready high.
    // Timing model: ph counts edges since the last accept; ph=5 is DONE,
    // and ph>=6 is IDLE.
    ph = 6;
    sent = 0;
    recvd = 0;
    cyc = 0;
    last_acc = 0;
    out_ready = 1'b1;
    in1 = 6'($urandom_range(0, 63));
    in2 = 6'($urandom_range(0, 63));
    in_valid = 1'b1;
    while (recvd < 16 && cyc < 300) begin
      exp_rdy = (ph >= 6);
      check("b2b_in_ready", 64'(in_ready), 64'(exp_rdy));
      check("b2b_busy", 64'(busy), 64'(!exp_rdy));
      check("b2b_out_valid", 64'(out_valid), 64'(ph == 5));
      if (out_valid && exp_q.size() > 0) begin
        check("b2b_product", 64'(dut_out), 64'(exp_q.pop_front()));
        recvd++;
      end
      will_acc = in_ready && in_valid;
      tick();
      cyc++;
      if (will_acc) begin
        exp_q.push_back(ref_mul(in1, in2));
        if (sent > 0) begin
          check("b2b_spacing", 64'(cyc - last_acc), 64'(6));
        end
        last_acc = cyc;
        sent++;
        ph = 1;
        in1 = 6'($urandom_range(0, 63));
        in2 = 6'($urandom_range(0, 63));
        in_valid = (sent < 16);
      end else if (ph < 100) begin
        ph++;
      end else begin
        ph = ph;
      end
    end
    check("b2b_count", 64'(recvd), 64'(16));
    in_valid = 1'b0;

    // WIDTH=9 instance, maximum operands
    tick();
    check("w9_ready", 64'(in9_ready), 64'(1));
    in9_a = 9'd511;
    in9_b = 9'd511;
    in9_valid = 1'b1;
    out9_ready = 1'b1;
    tick();
    in9_valid = 1'b0;
    n = 0;
    while (!out9_valid && n < 30) begin
      tick();
      n++;
    end
    check("w9_latency", 64'(n), 64'(9));
    check("w9_product", 64'(out9), 64'(261121));
    tick();
    check("w9_valid_drop", 64'(out9_valid), 64'(0));
    check("w9_busy_drop", 64'(busy9), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
